// File: rtl/ttl_counter_n.sv
// Presettable modulo-N counter in the style of a 74LS163, with cascadable rco and a wrap pulse.
// Define TTL_COUNTER_UPDOWN_EN to let the up port choose the count direction; otherwise it counts up only.
module ttl_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] din,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rco,
  output logic             wrap
);

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS is 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             dir_up_s;
  logic             count_en_s;

`ifdef TTL_COUNTER_UPDOWN_EN
  assign dir_up_s = up;
`else
  logic unused_up_s;
  assign unused_up_s = up;
  assign dir_up_s    = 1'b1;
`endif

  assign count_en_s = enp & ent;

  // Next-state: clear beats load beats count beats hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!sclr_n) begin
      q_d = ZERO_Q;
    end else if (!load_n) begin
      q_d = din;
    end else if (count_en_s) begin
      if (dir_up_s) begin
        // >= so an out-of-range loaded value returns to 0 on the next count.
        if (q_q >= MAX_Q) begin
          q_d    = ZERO_Q;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + ONE_Q;
        end
      end else begin
        if (q_q == ZERO_Q) begin
          q_d    = MAX_Q;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - ONE_Q;
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= ZERO_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count is purely a function of state and direction so cascades ripple without delay.
  assign tc   = dir_up_s ? (q_q == MAX_Q) : (q_q == ZERO_Q);
  assign rco  = tc & ent;
  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ttl_counter_n.sv
// Randomized bench for ttl_counter_n: a modulo-10 and a modulo-16 counter checked against an integer model,
// plus an 8-bit cascade of two modulo-16 stages.
module tb_ttl_counter_n;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       sclr_n = 1'b1;
  logic       load_n = 1'b1;
  logic [3:0] din = 4'd0;
  logic       enp = 1'b0;
  logic       ent = 1'b0;
  logic       up = 1'b1;
  logic       enp_c = 1'b0;
  logic       ent_c = 1'b0;

  logic [3:0] q_a, q_b, q_lo, q_hi;
  logic       tc_a, rco_a, wrap_a, tc_b, rco_b, wrap_b;
  logic       tc_lo, rco_lo, wrap_lo, tc_hi, rco_hi, wrap_hi;

  int vectors = 0;
  int miscompares = 0;

  int mq_a = 0, mw_a = 0, mq_b = 0, mw_b = 0, cnt_c = 0;

  ttl_counter_n #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .clr(clr), .sclr_n(sclr_n), .load_n(load_n), .din(din), .enp(enp), .ent(ent),
    .up(up), .q(q_a), .tc(tc_a), .rco(rco_a), .wrap(wrap_a));

  ttl_counter_n #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .clr(clr), .sclr_n(sclr_n), .load_n(load_n), .din(din), .enp(enp), .ent(ent),
    .up(up), .q(q_b), .tc(tc_b), .rco(rco_b), .wrap(wrap_b));

  ttl_counter_n #(.WIDTH(4)) dut_lo (
    .clk(clk), .clr(clr), .sclr_n(1'b1), .load_n(1'b1), .din(4'd0), .enp(enp_c), .ent(ent_c),
    .up(1'b1), .q(q_lo), .tc(tc_lo), .rco(rco_lo), .wrap(wrap_lo));

  ttl_counter_n #(.WIDTH(4)) dut_hi (
    .clk(clk), .clr(clr), .sclr_n(1'b1), .load_n(1'b1), .din(4'd0), .enp(enp_c), .ent(rco_lo),
    .up(1'b1), .q(q_hi), .tc(tc_hi), .rco(rco_hi), .wrap(wrap_hi));

  always #5 clk = ~clk;

  function automatic bit model_up();
`ifdef TTL_COUNTER_UPDOWN_EN
    return up;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int nxt_q(int qv, int m);
    if (!sclr_n) return 0;
    if (!load_n) return int'(din);
    if (!(enp && ent)) return qv;
    if (model_up()) return (qv >= m - 1) ? 0 : qv + 1;
    return (qv == 0) ? m - 1 : qv - 1;
  endfunction

  function automatic int nxt_w(int qv, int m);
    if (!sclr_n || !load_n || !(enp && ent)) return 0;
    if (model_up()) return (qv >= m - 1) ? 1 : 0;
    return (qv == 0) ? 1 : 0;
  endfunction

  function automatic int exp_tc(int qv, int m);
    if (model_up()) return (qv == m - 1) ? 1 : 0;
    return (qv == 0) ? 1 : 0;
  endfunction

  // Reference model: abstract integer counters that follow the same clock and asynchronous clear.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mq_a <= 0; mw_a <= 0; mq_b <= 0; mw_b <= 0; cnt_c <= 0;
    end else begin
      mq_a  <= nxt_q(mq_a, 10);
      mw_a  <= nxt_w(mq_a, 10);
      mq_b  <= nxt_q(mq_b, 16);
      mw_b  <= nxt_w(mq_b, 16);
      cnt_c <= (enp_c && ent_c) ? (cnt_c + 1) % 256 : cnt_c;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("q_a", 32'(q_a), 32'(mq_a));
    check_eq("wrap_a", 32'(wrap_a), 32'(mw_a));
    check_eq("tc_a", 32'(tc_a), 32'(exp_tc(mq_a, 10)));
    check_eq("rco_a", 32'(rco_a), 32'(exp_tc(mq_a, 10) & int'(ent)));
    check_eq("q_b", 32'(q_b), 32'(mq_b));
    check_eq("wrap_b", 32'(wrap_b), 32'(mw_b));
    check_eq("tc_b", 32'(tc_b), 32'(exp_tc(mq_b, 16)));
    check_eq("rco_b", 32'(rco_b), 32'(exp_tc(mq_b, 16) & int'(ent)));
  endtask

  task automatic check_casc();
    check_eq("casc_q", 32'({q_hi, q_lo}), 32'(cnt_c));
    check_eq("casc_rco_lo", 32'(rco_lo), 32'(((cnt_c % 16) == 15) && ent_c));
    check_eq("casc_rco_hi", 32'(rco_hi), 32'((cnt_c == 255) && ent_c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #2;
    check_all();
    clr = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state, held across a clock edge.
    up = 1'b1; enp = 1'b1; ent = 1'b1; din = 4'd9; load_n = 1'b0;
    #1 clr = 1'b1;
    #2;
    check_all();
    check_eq("rst_q_a", 32'(q_a), 32'd0);
    check_eq("rst_tc_b", 32'(tc_b), 32'(!model_up()));
    #4;
    check_all();
    clr = 1'b0;
    load_n = 1'b1;

    // Free count up from reset on both moduli.
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq("s16_q", 32'(q_b), 32'(i % 16));
      check_eq("s16_wrap", 32'(wrap_b), 32'((i % 16) == 0));
      check_eq("s10_q", 32'(q_a), 32'(i % 10));
    end

    // Load an out-of-range value into the modulo-10 counter, then count past it.
    din = 4'd12; load_n = 1'b0;
    tick();
    check_eq("ld12_q", 32'(q_a), 32'd12);
    load_n = 1'b1;
    tick();
    check_eq("ld12_next_q", 32'(q_a), 32'd0);
    check_eq("ld12_wrap", 32'(wrap_a), 32'd1);

    // Clear outranks load; load ignores the enables.
    din = 4'd7; load_n = 1'b0; sclr_n = 1'b0;
    tick();
    check_eq("sclr_q", 32'(q_a), 32'd0);
    sclr_n = 1'b1; enp = 1'b0; ent = 1'b0;
    tick();
    check_eq("ld_noen_q", 32'(q_a), 32'd7);
    load_n = 1'b1;

`ifdef TTL_COUNTER_UPDOWN_EN
    // Down count from reset, then reverse at 5.
    up = 1'b0; enp = 1'b1; ent = 1'b1;
    pulse_clr();
    check_eq("dn_tc0", 32'(tc_a), 32'd1);
    tick();
    check_eq("dn_q9", 32'(q_a), 32'd9);
    check_eq("dn_wrap", 32'(wrap_a), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check_eq("dn_q5", 32'(q_a), 32'd5);
    up = 1'b1;
    tick();
    check_eq("dn_rev_q6", 32'(q_a), 32'd6);
`endif

    // Asynchronous clear while a load is pending, held over an edge, released between edges.
    up = 1'b1; enp = 1'b0; ent = 1'b0; din = 4'd5; load_n = 1'b0;
    tick();
    check_eq("pre_clr_q5", 32'(q_a), 32'd5);
    din = 4'd9;
    #2 clr = 1'b1;
    #1;
    check_eq("aclr_q", 32'(q_a), 32'd0);
    check_eq("aclr_wrap", 32'(wrap_a), 32'd0);
    tick();
    check_eq("aclr_hold_q", 32'(q_a), 32'd0);
    #2 clr = 1'b0;
    tick();
    check_eq("post_clr_ld", 32'(q_a), 32'd9);
    load_n = 1'b1;

    // Randomized traffic against the model, with occasional mid-cycle clears.
    for (int i = 0; i < 600; i++) begin
      sclr_n = ($urandom_range(0, 15) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      din    = 4'($urandom);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom);
      #1;
      check_all();
      if ($urandom_range(0, 39) == 0) pulse_clr();
      tick();
    end

    // Two-stage cascade: 256 counts roll 255 back to 0, then ent low freezes both.
    sclr_n = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0;
    pulse_clr();
    enp_c = 1'b1; ent_c = 1'b1;
    #1;
    check_casc();
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      check_casc();
      if (i == 255) begin
        check_eq("casc_255", 32'({q_hi, q_lo}), 32'd255);
        check_eq("casc_rco255", 32'(rco_hi), 32'd1);
      end
    end
    check_eq("casc_roll", 32'({q_hi, q_lo}), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    ent_c = 1'b0;
    #1;
    check_eq("casc_frz_rco", 32'(rco_lo), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_casc();
    end
    check_eq("casc_frz_q", 32'({q_hi, q_lo}), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
